// File: rtl/vga_timing_receiver.sv
// Rebuilds VGA pixel position from active-low sync edges, measures line/frame timing and qualifies lock.
// Optional DE_CHECK_EN adds a de_in port that is cross-checked against the recovered visible window.
module vga_timing_receiver #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25MHz,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
`ifdef DE_CHECK_EN
    input  logic        de_in,
`endif
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_active,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  X_SYNC      = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  X_VIS       = 10'(H_DISPLAY);
    localparam logic [9:0]  Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_SYNC      = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  Y_VIS       = 10'(V_DISPLAY);
    localparam logic [10:0] LINE_NOM    = 11'(H_TOTAL);
    localparam logic [10:0] LOSS_LAST   = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  FRAME_NOM   = 10'(V_TOTAL);
    localparam logic [7:0]  GOOD_TARGET = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [9:0]  rxX_q, rxX_d, rxY_q, rxY_d;
    logic [10:0] lineCnt_q, lineCnt_d, lineLen_q, lineLen_d, lineMeas;
    logic [9:0]  hCount_q, hCount_d, frameLines_q, frameLines_d;
    logic        lineErr_q, lineErr_d, lineValid_q, lineValid_d;
    logic        locked_q, locked_d;
    logic [7:0]  goodCnt_q, goodCnt_d, errCount_q, errCount_d, errInc;
    logic        hFall, vFall, inVis, lineBad, deBad, lossEvt, frameGood;

    assign hFall     = hs_q & ~hsync_in;
    assign vFall     = vs_q & ~vsync_in;
    assign inVis     = (rxX_q < X_VIS) && (rxY_q < Y_VIS);
    assign lineMeas  = (lineCnt_q == 11'h7FF) ? lineCnt_q : lineCnt_q + 11'd1;
    assign lineBad   = hFall && lineValid_q && (lineMeas != LINE_NOM);
    assign lossEvt   = !hFall && (lineCnt_q == LOSS_LAST);
    assign frameGood = (hCount_q == FRAME_NOM) && !lineErr_q;
    assign errInc    = (errCount_q == 8'hFF) ? errCount_q : errCount_q + 8'd1;

`ifdef DE_CHECK_EN
    logic de_q;

    assign deBad = (state_q != SEARCH) && (de_q != inVis);

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) de_q <= 1'b0;
        else          de_q <= de_in;
    end
`else
    assign deBad = 1'b0;
`endif

    always_comb begin
        rxX_d        = (rxX_q == X_LAST) ? 10'd0 : rxX_q + 10'd1;
        rxY_d        = rxY_q;
        lineCnt_d    = (lineCnt_q == 11'h7FF) ? lineCnt_q : lineCnt_q + 11'd1;
        lineLen_d    = lineLen_q;
        hCount_d     = hCount_q;
        frameLines_d = frameLines_q;
        lineErr_d    = vFall ? 1'b0 : lineErr_q;
        lineValid_d  = lineValid_q;
        state_d      = state_q;
        goodCnt_d    = goodCnt_q;
        errCount_d   = errCount_q;

        if (hFall) begin
            rxX_d       = X_SYNC;
            lineCnt_d   = 11'd0;
            lineLen_d   = lineMeas;
            lineValid_d = 1'b1;
        end
        if (vFall)
            rxY_d = Y_SYNC;
        else if (!hFall && rxX_q == X_LAST)
            rxY_d = (rxY_q == Y_LAST) ? 10'd0 : rxY_q + 10'd1;

        // A sync fall coinciding with vsync belongs to the frame that is starting.
        if (vFall) begin
            frameLines_d = hCount_q;
            hCount_d     = hFall ? 10'd1 : 10'd0;
        end else if (hFall && hCount_q != 10'h3FF) begin
            hCount_d = hCount_q + 10'd1;
        end
        if (lineBad || deBad)
            lineErr_d = 1'b1;

        if (lossEvt) begin
            state_d = SEARCH;
            if (state_q == LOCKED) errCount_d = errInc;
        end else if (vFall) begin
            case (state_q)
                SEARCH: begin
                    state_d   = CHECK;
                    goodCnt_d = 8'd0;
                end
                CHECK: begin
                    if (frameGood) begin
                        goodCnt_d = goodCnt_q + 8'd1;
                        if (goodCnt_q + 8'd1 >= GOOD_TARGET) state_d = LOCKED;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!frameGood) begin
                        state_d    = SEARCH;
                        errCount_d = errInc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Re-entering SEARCH discards the line reference so the next period is not judged.
        if (state_d == SEARCH && state_q != SEARCH)
            lineValid_d = 1'b0;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            rxX_q        <= '0;
            rxY_q        <= '0;
            lineCnt_q    <= '0;
            lineLen_q    <= '0;
            hCount_q     <= '0;
            frameLines_q <= '0;
            lineErr_q    <= 1'b0;
            lineValid_q  <= 1'b0;
            state_q      <= SEARCH;
            goodCnt_q    <= '0;
            errCount_q   <= '0;
            locked_q     <= 1'b0;
        end else begin
            hs_q         <= hsync_in;
            vs_q         <= vsync_in;
            rxX_q        <= rxX_d;
            rxY_q        <= rxY_d;
            lineCnt_q    <= lineCnt_d;
            lineLen_q    <= lineLen_d;
            hCount_q     <= hCount_d;
            frameLines_q <= frameLines_d;
            lineErr_q    <= lineErr_d;
            lineValid_q  <= lineValid_d;
            state_q      <= state_d;
            goodCnt_q    <= goodCnt_d;
            errCount_q   <= errCount_d;
            locked_q     <= locked_d;
        end
    end

    assign rx_x        = rxX_q;
    assign rx_y        = rxY_q;
    assign locked      = locked_q;
    assign rx_active   = locked_q && inVis;
    assign line_len    = lineLen_q;
    assign frame_lines = frameLines_q;
    assign err_count   = errCount_q;
endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a scaled-down 56x28 timing so lock is reached quickly.
// Covers reset, clean lock, short line, loss of signal, short frame, mid-frame reset and optional DE check.
module tb_vga_timing_receiver;
    localparam int HD = 32, HF = 4, HS = 8, HB = 12, HT = HD + HF + HS + HB;
    localparam int VD = 20, VF = 2, VS = 2, VB = 4, VT = VD + VF + VS + VB;
    localparam int HS0 = HD + HF, HS1 = HD + HF + HS;
    localparam int VS0 = VD + VF, VS1 = VD + VF + VS;

    logic        clk_25MHz;
    logic        reset_n;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic        rx_active;
    logic        locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_count;
`ifdef DE_CHECK_EN
    logic        de_in;
    logic        lastDe;
    int          deDelayY;
`endif

    int tests, fails;
    int srcX, srcY, prevX, prevY, lineLen, frameLen;
    bit hsForce;

    vga_timing_receiver #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .reset_n     (reset_n),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
`ifdef DE_CHECK_EN
        .de_in       (de_in),
`endif
        .rx_x        (rx_x),
        .rx_y        (rx_y),
        .rx_active   (rx_active),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .err_count   (err_count)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // One pixel of the source: drive syncs for (srcX, srcY), clock it in, then advance the raster.
    task automatic tick();
`ifdef DE_CHECK_EN
        logic curDe;
        curDe  = (srcX < HD) && (srcY < VD);
        de_in  = (srcY == deDelayY) ? lastDe : curDe;
        lastDe = curDe;
`endif
        hsync_in = hsForce ? 1'b1 : !((srcX >= HS0) && (srcX < HS1));
        vsync_in = !((srcY >= VS0) && (srcY < VS1));
        @(posedge clk_25MHz);
        #1;
        prevX = srcX;
        prevY = srcY;
        if (srcX == lineLen - 1) begin
            srcX    = 0;
            lineLen = HT;
            if (srcY == frameLen - 1) begin
                srcY     = 0;
                frameLen = VT;
            end else begin
                srcY++;
            end
        end else begin
            srcX++;
        end
    endtask

    task automatic runTo(input int y, input int x);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(prevY == y && prevX == x) && n < 4 * HT * VT);
        if (!(prevY == y && prevX == x)) begin
            tests++;
            fails++;
            $display("[TB] FAIL run_to: stopped at (%0d,%0d), required (%0d,%0d)", prevX, prevY, x, y);
        end
    endtask

    task automatic doReset();
        reset_n  = 1'b0;
        srcX     = 0;
        srcY     = 0;
        lineLen  = HT;
        frameLen = VT;
        hsForce  = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        @(posedge clk_25MHz);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hsync_in = (i % 2 == 0);
            vsync_in = (i % 4 < 2);
            @(posedge clk_25MHz);
            #1;
        end
        tests++; if (rx_x !== 10'd0) begin fails++; $display("[TB] FAIL reset_rx_x: got %0d, required 0", rx_x); end
        tests++; if (rx_y !== 10'd0) begin fails++; $display("[TB] FAIL reset_rx_y: got %0d, required 0", rx_y); end
        tests++; if (line_len !== 11'd0) begin fails++; $display("[TB] FAIL reset_line_len: got %0d, required 0", line_len); end
        tests++; if (frame_lines !== 10'd0) begin fails++; $display("[TB] FAIL reset_frame_lines: got %0d, required 0", frame_lines); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("[TB] FAIL reset_err_count: got %0d, required 0", err_count); end
        tests++; if (locked !== 1'b0 || rx_active !== 1'b0) begin fails++; $display("[TB] FAIL reset_lock: locked=%b active=%b, required 0/0", locked, rx_active); end

        hsync_in = 1'b1;
        vsync_in = 1'b1;
        reset_n  = 1'b1;
        repeat (10) begin
            @(posedge clk_25MHz);
            #1;
        end
        tests++; if (rx_x !== 10'd10) begin fails++; $display("[TB] FAIL release_rx_x: got %0d, required 10", rx_x); end
        tests++; if (line_len !== 11'd0 || frame_lines !== 10'd0) begin fails++; $display("[TB] FAIL release_no_edge: line_len=%0d frame_lines=%0d, required 0/0", line_len, frame_lines); end
    endtask

    task automatic test_clean_lock();
        int posErr, activeErr, activeCnt;
        doReset();
        runTo(0, HS0);
        tests++; if (line_len !== 11'(HS0 + 1)) begin fails++; $display("[TB] FAIL first_line_len: got %0d, required %0d", line_len, HS0 + 1); end
        runTo(1, HS0);
        tests++; if (line_len !== 11'(HT)) begin fails++; $display("[TB] FAIL clean_line_len: got %0d, required %0d", line_len, HT); end
        runTo(VS0, 0);
        tests++; if (frame_lines !== 10'(VS0)) begin fails++; $display("[TB] FAIL first_frame_lines: got %0d, required %0d", frame_lines, VS0); end
        runTo(VS0, 0);
        tests++; if (frame_lines !== 10'(VT) || locked !== 1'b0) begin fails++; $display("[TB] FAIL clean_frame_lines: got %0d locked=%b, required %0d/0", frame_lines, locked, VT); end
        runTo(VS0 - 1, HT - 1);
        tests++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL lock_early: got %b, required 0", locked); end
        tick();
        tests++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL lock_rise: got %b, required 1", locked); end

        posErr = 0; activeErr = 0; activeCnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (rx_x !== 10'(prevX) || rx_y !== 10'(prevY)) posErr++;
            if (rx_active !== ((prevX < HD) && (prevY < VD))) activeErr++;
            if (rx_active === 1'b1) activeCnt++;
        end
        tests++; if (posErr !== 0) begin fails++; $display("[TB] FAIL position_track: %0d cycles off, required 0", posErr); end
        tests++; if (activeErr !== 0) begin fails++; $display("[TB] FAIL active_window: %0d cycles wrong, required 0", activeErr); end
        tests++; if (activeCnt !== HD * VD) begin fails++; $display("[TB] FAIL active_count: got %0d, required %0d", activeCnt, HD * VD); end
    endtask

    task automatic test_short_line();
        runTo(5, 0);
        lineLen = HT - 1;
        runTo(6, HS0);
        tests++; if (line_len !== 11'(HT - 1) || locked !== 1'b1) begin fails++; $display("[TB] FAIL short_line_len: got %0d locked=%b, required %0d/1", line_len, locked, HT - 1); end
        runTo(VS0, 0);
        tests++; if (locked !== 1'b0 || err_count !== 8'd1) begin fails++; $display("[TB] FAIL short_line_drop: locked=%b err=%0d, required 0/1", locked, err_count); end
        runTo(VS0, 0);
        runTo(VS0, 0);
        tests++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL relock_early: got %b, required 0", locked); end
        runTo(VS0, 0);
        tests++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL relock: got %b, required 1", locked); end
    endtask

    task automatic test_loss_of_signal();
        runTo(3, HS0);
        hsForce = 1'b1;
        repeat (2 * HT - 1) tick();
        tests++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL loss_early: got %b, required 1", locked); end
        tick();
        tests++; if (locked !== 1'b0 || err_count !== 8'd2) begin fails++; $display("[TB] FAIL loss_drop: locked=%b err=%0d, required 0/2", locked, err_count); end
        tests++; if (line_len !== 11'(HT)) begin fails++; $display("[TB] FAIL loss_line_len: got %0d, required %0d", line_len, HT); end
        hsForce = 1'b0;
        runTo(VS0, 0);
        runTo(VS0, 0);
        runTo(VS0, 0);
        tests++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL loss_relock: got %b, required 1", locked); end
    endtask

    task automatic test_short_frame();
        runTo(5, 0);
        frameLen = VT - 1;
        runTo(VS0, 0);
        tests++; if (frame_lines !== 10'(VT) || locked !== 1'b1) begin fails++; $display("[TB] FAIL pre_short_frame: lines=%0d locked=%b, required %0d/1", frame_lines, locked, VT); end
        runTo(VS0, 0);
        tests++; if (frame_lines !== 10'(VT - 1)) begin fails++; $display("[TB] FAIL short_frame_lines: got %0d, required %0d", frame_lines, VT - 1); end
        tests++; if (locked !== 1'b0 || err_count !== 8'd3) begin fails++; $display("[TB] FAIL short_frame_drop: locked=%b err=%0d, required 0/3", locked, err_count); end
    endtask

    task automatic test_reset_mid_frame();
        runTo(10, 5);
        reset_n = 1'b0;
        #1;
        tests++; if (rx_x !== 10'd0 || rx_y !== 10'd0) begin fails++; $display("[TB] FAIL midreset_pos: got (%0d,%0d), required (0,0)", rx_x, rx_y); end
        tests++; if (line_len !== 11'd0 || frame_lines !== 10'd0) begin fails++; $display("[TB] FAIL midreset_meas: got %0d/%0d, required 0/0", line_len, frame_lines); end
        tests++; if (err_count !== 8'd0 || locked !== 1'b0) begin fails++; $display("[TB] FAIL midreset_status: err=%0d locked=%b, required 0/0", err_count, locked); end
        @(posedge clk_25MHz);
        #1;
        reset_n = 1'b1;
    endtask

`ifdef DE_CHECK_EN
    task automatic test_de_check();
        doReset();
        runTo(VS0, 0);
        runTo(VS0, 0);
        runTo(VS0, 0);
        tests++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL de_lock: got %b, required 1", locked); end
        deDelayY = 5;
        runTo(VS0, 0);
        deDelayY = -1;
        tests++; if (locked !== 1'b0 || err_count !== 8'd1) begin fails++; $display("[TB] FAIL de_drop: locked=%b err=%0d, required 0/1", locked, err_count); end
    endtask
`endif

    initial begin
        clk_25MHz = 1'b0;
        reset_n   = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        tests     = 0;
        fails     = 0;
        hsForce   = 1'b0;
        srcX = 0; srcY = 0; prevX = 0; prevY = 0;
        lineLen  = HT;
        frameLen = VT;
`ifdef DE_CHECK_EN
        de_in    = 1'b0;
        lastDe   = 1'b0;
        deDelayY = -1;
`endif
        test_reset();
        test_clean_lock();
        test_short_line();
        test_loss_of_signal();
        test_short_frame();
        test_reset_mid_frame();
`ifdef DE_CHECK_EN
        test_de_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
